// File: rtl/iclk_div_ctrl.sv
// Run/stop and reconfiguration controller: divides clk100mhz by period P into clk_out, starting/stopping only on period boundaries.
// Optional ICLK_PERIOD_CNT_EN adds a 16-bit period_count output counting tick_rise pulses.
module iclk_div_ctrl #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DEFAULT_PERIOD = 25
) (
    input  logic             clk100mhz,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             run_req,
    output logic             run_ack,
    output logic             clk_out,
    output logic             tick_rise
`ifdef ICLK_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_count
`endif
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_p, cur_p_nxt;
    logic [CNT_W-1:0] pend_p, pend_p_nxt;
    logic [CNT_W-1:0] half_p;
    logic             pend, pend_nxt;
    logic             clk_nxt, tick_nxt, ack_nxt;
    logic             boundary, accept;

    assign cfg_ready = ~pend;
    assign accept    = cfg_valid & ~pend;
    assign half_p    = cur_p >> 1;
    assign boundary  = (cnt == cur_p - CNT_W'(1));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cur_p_nxt  = cur_p;
        pend_nxt   = pend;
        pend_p_nxt = pend_p;
        clk_nxt    = clk_out;
        tick_nxt   = 1'b0;
        ack_nxt    = run_ack;

        case (state)
            ST_STOP: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                ack_nxt = 1'b0;
                if (pend) begin
                    cur_p_nxt = pend_p;
                    pend_nxt  = 1'b0;
                end
                if (run_req) begin
                    state_nxt = ST_RUN;
                    clk_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                    ack_nxt   = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                ack_nxt   = 1'b1;
                state_nxt = run_req ? ST_RUN : ST_DRAIN;
                if (boundary) begin
                    if (pend) begin
                        cur_p_nxt = pend_p;
                        pend_nxt  = 1'b0;
                    end
                    cnt_nxt = '0;
                    // Only a drain that is still unwanted at the boundary stops; RUN always starts one more period.
                    if (state == ST_DRAIN && !run_req) begin
                        state_nxt = ST_STOP;
                        clk_nxt   = 1'b0;
                        ack_nxt   = 1'b0;
                    end else begin
                        clk_nxt  = 1'b1;
                        tick_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    clk_nxt = (cnt_nxt < half_p);
                end
            end
            default: begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
                ack_nxt   = 1'b0;
            end
        endcase

        if (accept) begin
            pend_nxt   = 1'b1;
            pend_p_nxt = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state     <= ST_STOP;
            cnt       <= '0;
            cur_p     <= CNT_W'(DEFAULT_PERIOD);
            pend_p    <= CNT_W'(DEFAULT_PERIOD);
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            run_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_p     <= cur_p_nxt;
            pend_p    <= pend_p_nxt;
            pend      <= pend_nxt;
            clk_out   <= clk_nxt;
            tick_rise <= tick_nxt;
            run_ack   <= ack_nxt;
        end
    end

`ifdef ICLK_PERIOD_CNT_EN
    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            period_count <= '0;
        end else if (tick_nxt) begin
            period_count <= period_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iclk_div_ctrl.sv
// Scoreboard bench for iclk_div_ctrl: expected {run_ack, cfg_ready, clk_out, tick_rise} per cycle are queued, then popped after each edge.
module tb_iclk_div_ctrl;

    logic       clk100mhz = 1'b0;
    logic       reset;
    logic [7:0] cfg_period;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       run_req;
    logic       run_ack;
    logic       clk_out;
    logic       tick_rise;
`ifdef ICLK_PERIOD_CNT_EN
    logic [15:0] period_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs;

    assign obs = {run_ack, cfg_ready, clk_out, tick_rise};

    always #5 clk100mhz = ~clk100mhz;

    iclk_div_ctrl #(
        .CNT_W         (8),
        .DEFAULT_PERIOD(25)
    ) dut (
        .clk100mhz (clk100mhz),
        .reset     (reset),
        .cfg_period(cfg_period),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .run_req   (run_req),
        .run_ack   (run_ack),
        .clk_out   (clk_out),
        .tick_rise (tick_rise)
`ifdef ICLK_PERIOD_CNT_EN
        ,
        .period_count(period_count)
`endif
    );

    task automatic step();
        @(posedge clk100mhz);
        #1;
    endtask

    // One running period of length p: high for p/2 cycles, tick on the first.
    task automatic push_period(input int p, input logic rdy);
        for (int k = 0; k < p; k++)
            exp_q.push_back({1'b1, rdy, (k < p / 2), (k == 0)});
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back(4'b0100);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        run_req    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        step();
        step();
        checks++;
        if (obs !== 4'b0100) begin
            errors++;
            $display("FAIL reset_state got %b want 0100", obs);
        end
        reset = 1'b0;
    endtask

    task automatic test_run();
        logic [3:0] e;
        int n;
        for (int r = 0; r < 3; r++) push_period(25, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            run_req = 1'b1;
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL run cyc %0d got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reconfig();
        logic [3:0] e;
        int n;
        for (int k = 0; k < 25; k++)
            exp_q.push_back({1'b1, (k <= 5), (k < 12), (k == 0)});
        push_period(10, 1'b1);
        push_period(10, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cfg_valid  = (i == 6);
            cfg_period = 8'd10;
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL reconfig cyc %0d got %b want %b", i, obs, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_drain();
        logic [3:0] e;
        int n;
        push_period(10, 1'b0);
        push_period(25, 1'b1);
        push_idle(20);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cfg_valid  = (i == 0);
            cfg_period = 8'd25;
            run_req    = (i < 14);
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL drain cyc %0d got %b want %b", i, obs, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_drain_boundary();
        logic [3:0] e;
        int n;
        push_period(25, 1'b1);
        push_period(25, 1'b1);
        push_idle(10);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            run_req = (i < 25) || (i >= 30 && i < 35);
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL drain_boundary cyc %0d got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_clamp();
        logic [3:0] e;
        int n;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        for (int r = 0; r < 8; r++) push_period(2, 1'b1);
        push_period(2, 1'b0);
        for (int r = 0; r < 3; r++) push_period(2, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cfg_valid  = (i == 0) || (i == 18);
            cfg_period = (i == 0) ? 8'd1 : 8'd0;
            run_req    = (i >= 2);
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL clamp cyc %0d got %b want %b", i, obs, e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        int n;
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b1000);
        for (int k = 0; k <= 6; k++)
            exp_q.push_back({1'b1, (k < 6), (k < 12), (k == 0)});
        exp_q.push_back(4'b0100);
        push_period(25, 1'b1);
        push_period(25, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cfg_valid  = (i == 0) || (i == 8);
            cfg_period = (i == 0) ? 8'd25 : 8'd7;
            reset      = (i == 9);
            run_req    = 1'b1;
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 40) $display("FAIL reset_mid cyc %0d got %b want %b", i, obs, e);
            end
        end
        cfg_valid = 1'b0;
        reset     = 1'b0;
    endtask

`ifdef ICLK_PERIOD_CNT_EN
    task automatic test_period_count();
        int ticks;
        int cyc;
        reset   = 1'b1;
        run_req = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if (period_count !== 16'd0) begin
            errors++;
            $display("FAIL pcount_reset got %0d want 0", period_count);
        end
        cfg_valid  = 1'b1;
        cfg_period = 8'd2;
        step();
        cfg_valid = 1'b0;
        step();
        run_req = 1'b1;
        ticks = 0;
        cyc   = 0;
        while (ticks < 100 && cyc < 1000) begin
            step();
            cyc++;
            if (tick_rise === 1'b1) ticks++;
        end
        run_req = 1'b0;
        checks++;
        if (ticks != 100) begin
            errors++;
            $display("FAIL pcount_timeout got %0d ticks want 100", ticks);
        end
        checks++;
        if (period_count !== 16'd100) begin
            errors++;
            $display("FAIL pcount_100 got %0d want 100", period_count);
        end
        repeat (10) step();
        checks++;
        if (period_count !== 16'd100) begin
            errors++;
            $display("FAIL pcount_hold got %0d want 100", period_count);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        run_req    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        test_reset();
        test_run();
        test_reconfig();
        test_drain();
        test_drain_boundary();
        test_clamp();
        test_reset_mid();
`ifdef ICLK_PERIOD_CNT_EN
        test_period_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
